// File: rtl/count_seq_ctrl_pkg.sv
// Shared types for the counter sequencer: command opcodes and FSM states.
// Imported by the controller and its command interface.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Command channel into the sequencer: one valid/ready handshake
// carrying opcode, load value and step count.
interface count_seq_ctrl_if #(
  parameter int N  = 8,
  parameter int SW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [N-1:0]  cmd_data;
  logic [SW-1:0] cmd_steps;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/shift_reg_exercice.sv
// N-bit up/down counter driven by the sequencer.
// Priority: syn_clr, then load, then en.
module shift_reg_exercice #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (syn_clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= up ? q + N'(1) : q - N'(1);
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Command sequencer for shift_reg_exercice: turns one accepted command
// into the exact run of counter control cycles, then pulses done.
import count_ctrl_pkg::*;

module count_seq_ctrl #(
  parameter int N  = 8,
  parameter int SW = 8
) (
  input  logic                clk,
  input  logic                rst,
  count_seq_ctrl_if.slave     cmd,
  input  logic                pause,
  input  logic                abort,
  output logic                cnt_syn_clr,
  output logic                cnt_load,
  output logic                cnt_en,
  output logic                cnt_up,
  output logic [N-1:0]        cnt_d,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [SW-1:0]       rem
);

  state_e        state;
  logic          hs;
  op_e           op;
  logic [SW-1:0] rem_nxt;

  assign hs = cmd.cmd_valid && cmd.cmd_ready;
  assign op = op_e'(cmd.cmd_op);

  // rem counts down once per enabled cycle that just ended
  assign rem_nxt = cnt_en ? rem - SW'(1) : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd.cmd_ready <= 1'b1;
      cnt_syn_clr   <= 1'b0;
      cnt_load      <= 1'b0;
      cnt_en        <= 1'b0;
      cnt_up        <= 1'b1;
      cnt_d         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      rem           <= '0;
    end else begin
      cnt_syn_clr <= 1'b0;
      cnt_load    <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (hs) begin
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            aborted       <= 1'b0;
            unique case (op)
              OP_CLR: begin
                cnt_syn_clr <= 1'b1;
                state       <= S_CLR;
              end
              OP_LOAD: begin
                cnt_load <= 1'b1;
                cnt_d    <= cmd.cmd_data;
                state    <= S_LOAD;
              end
              default: begin
                cnt_up <= (op == OP_UP);
                rem    <= cmd.cmd_steps;
                if (cmd.cmd_steps == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  state  <= S_COUNT;
                  cnt_en <= !pause;
                end
              end
            endcase
          end
        end
        S_CLR, S_LOAD: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_COUNT: begin
          rem <= rem_nxt;
          if (abort) begin
            cnt_en  <= 1'b0;
            state   <= S_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (rem_nxt == '0) begin
            cnt_en <= 1'b0;
            state  <= S_DONE;
            done   <= 1'b1;
          end else begin
            cnt_en <= !pause;
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          cmd.cmd_ready <= 1'b1;
          busy          <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl driving shift_reg_exercice: directed plan
// steps followed by random commands checked against a behavioural model.
module tb_count_seq_ctrl;

  localparam int N  = 8;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_rst;
  logic          pause;
  logic          abort;
  logic          cnt_syn_clr;
  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_up;
  logic [N-1:0]  cnt_d;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [SW-1:0] rem;
  logic [N-1:0]  q;

  int checks = 0;
  int errs   = 0;
  logic [7:0] q_model;

  always #5 clk = ~clk;

  count_seq_ctrl_if #(.N(N), .SW(SW)) cmd_if ();

  count_seq_ctrl #(.N(N), .SW(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .pause       (pause),
    .abort       (abort),
    .cnt_syn_clr (cnt_syn_clr),
    .cnt_load    (cnt_load),
    .cnt_en      (cnt_en),
    .cnt_up      (cnt_up),
    .cnt_d       (cnt_d),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .rem         (rem)
  );

  shift_reg_exercice #(8) counter (
    .clk     (clk),
    .reset   (cnt_rst),
    .syn_clr (cnt_syn_clr),
    .load    (cnt_load),
    .en      (cnt_en),
    .up      (cnt_up),
    .d       (cnt_d),
    .q       (q)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command at a negedge and follow it to completion.
  // Pause is high at edges ps..ps+pl-1 counted from the handshake edge;
  // abort rises once ab_after enabled cycles have been seen.
  task automatic run_cmd(input int op, input int data, input int steps,
                         input int ps, input int pl, input int ab_after,
                         output int lat);
    int  en_seen, sc, ld, exp_en, lastj, exp_lat, n, w;
    bit  got_done, will_abort;
    will_abort = (op >= 2) && (ab_after > 0) && (ab_after < steps);
    w = 0;
    while (cmd_if.cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_cmd", 32'(cmd_if.cmd_ready), 32'(1));
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op[1:0];
    cmd_if.cmd_data  = data[N-1:0];
    cmd_if.cmd_steps = steps[SW-1:0];
    pause = (ps == 0) && (pl > 0);
    abort = 1'b0;
    @(posedge clk);
    en_seen  = 0;
    sc       = 0;
    ld       = 0;
    got_done = 1'b0;
    lat      = 0;
    for (int k = 1; k <= 300 && !got_done; k++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      if (op >= 2) chk("rem_track", 32'(rem), 32'(steps - en_seen));
      if (cnt_en) en_seen++;
      if (cnt_syn_clr) sc++;
      if (cnt_load) begin
        ld++;
        chk("cnt_d_load", 32'(cnt_d), 32'(data[N-1:0]));
      end
      if (done) begin
        got_done = 1'b1;
        lat      = k;
      end else begin
        pause = (k >= ps) && (k < ps + pl);
        if (will_abort && en_seen == ab_after) abort = 1'b1;
      end
    end
    chk("done_seen", 32'(got_done), 32'(1));
    chk("busy_at_done", 32'(busy), 32'(1));
    chk("ready_at_done", 32'(cmd_if.cmd_ready), 32'(0));
    case (op)
      0: begin q_model = 8'h00; exp_en = 0; end
      1: begin q_model = data[7:0]; exp_en = 0; end
      default: begin
        exp_en  = will_abort ? ab_after : steps;
        q_model = (op == 2) ? q_model + 8'(exp_en) : q_model - 8'(exp_en);
      end
    endcase
    if (op < 2) begin
      exp_lat = 2;
    end else if (steps == 0) begin
      exp_lat = 1;
    end else begin
      n = 0;
      lastj = 0;
      for (int j = 0; n < steps && j < 1000; j++) begin
        if (!(j >= ps && j < ps + pl)) begin
          n++;
          lastj = j;
        end
      end
      exp_lat = lastj + 2;
    end
    chk("en_cycles", 32'(en_seen), 32'(exp_en));
    chk("clr_cycles", 32'(sc), 32'(op == 0));
    chk("load_cycles", 32'(ld), 32'(op == 1));
    chk("aborted", 32'(aborted), 32'(will_abort));
    chk("q_at_done", 32'(q), 32'(q_model));
    if (!will_abort) chk("latency", 32'(lat), 32'(exp_lat));
    if (op >= 2) chk("cnt_up", 32'(cnt_up), 32'(op == 2));
    pause = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'(0));
    chk("ready_after", 32'(cmd_if.cmd_ready), 32'(1));
    chk("busy_after", 32'(busy), 32'(0));
  endtask

  initial begin
    int lat, op, steps, ps, pl, ab;
    logic [N-1:0] q_hold;
    rst              = 1'b1;
    cnt_rst          = 1'b1;
    pause            = 1'b0;
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_steps = '0;
    q_model          = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    cnt_rst = 1'b0;

    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_up", 32'(cnt_up), 32'(1));
    chk("rst_en", 32'(cnt_en), 32'(0));
    chk("rst_clr", 32'(cnt_syn_clr), 32'(0));
    chk("rst_load", 32'(cnt_load), 32'(0));
    chk("rst_d", 32'(cnt_d), 32'(0));
    chk("rst_rem", 32'(rem), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_q", 32'(q), 32'(0));

    run_cmd(1, 'hA5, 0, 0, 0, 0, lat);
    run_cmd(2, 0, 3, 0, 0, 0, lat);
    chk("up3_q", 32'(q), 32'h0A8);
    chk("up3_lat", 32'(lat), 32'(4));

    run_cmd(3, 0, 2, 1, 2, 0, lat);
    chk("down2_pause_q", 32'(q), 32'h0A6);
    chk("down2_pause_lat", 32'(lat), 32'(5));

    run_cmd(0, 0, 0, 0, 0, 0, lat);
    chk("clr_q", 32'(q), 32'h000);
    run_cmd(1, 'h3C, 0, 0, 0, 0, lat);
    chk("load3c_q", 32'(q), 32'h03C);
    run_cmd(2, 0, 2, 0, 0, 0, lat);
    chk("up2_q", 32'(q), 32'h03E);

    run_cmd(1, 'hFE, 0, 0, 0, 0, lat);
    run_cmd(2, 0, 10, 0, 0, 3, lat);
    chk("abort_q", 32'(q), 32'h001);
    chk("abort_rem", 32'(rem), 32'(7));

    run_cmd(2, 0, 0, 0, 0, 0, lat);
    chk("steps0_lat", 32'(lat), 32'(1));

    for (int i = 0; i < 25; i++) begin
      op    = int'($urandom_range(0, 3));
      steps = int'($urandom_range(0, 12));
      ps    = int'($urandom_range(0, 6));
      pl    = int'($urandom_range(0, 3));
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
      run_cmd(op, int'($urandom_range(0, 255)), steps, ps, pl, ab, lat);
    end

    // async reset in the middle of a long count
    run_cmd(1, 'h5A, 0, 0, 0, 0, lat);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'd2;
    cmd_if.cmd_steps = 8'd20;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    q_hold = q;
    rst    = 1'b1;
    #1;
    chk("arst_ready", 32'(cmd_if.cmd_ready), 32'(1));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_en", 32'(cnt_en), 32'(0));
    chk("arst_up", 32'(cnt_up), 32'(1));
    chk("arst_load", 32'(cnt_load), 32'(0));
    chk("arst_clr", 32'(cnt_syn_clr), 32'(0));
    chk("arst_d", 32'(cnt_d), 32'(0));
    chk("arst_rem", 32'(rem), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_aborted", 32'(aborted), 32'(0));
    chk("arst_q_mid", 32'(q), 32'h05A + 32'(5));
    @(posedge clk);
    #1;
    chk("arst_q_hold", 32'(q), 32'(q_hold));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_arst_ready", 32'(cmd_if.cmd_ready), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
